qpd_burst_capture: RTL and testbench

- Downstream consumer of the quarter-period delay stage. It takes that stage's one-cycle `trigger` pulse and captures a burst of `burst_len` ADC samples into an internal FIFO.
- Captured samples are streamed out over a valid/ready interface to the readout/host path.
- It reports busy, overflow and a completion pulse so the C server can sequence measurements.

---
 rtl/qpd_capture_pkg.sv | 19 +
 rtl/qpd_burst_capture_if.sv | 14 +
 rtl/qpd_capture_fifo.sv | 42 ++++
 rtl/qpd_burst_capture.sv | 119 +++++++++++
 tb/tb_qpd_burst_capture.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/qpd_capture_pkg.sv
// Shared types and constants for the burst capture block.
package qpd_capture_pkg;

    localparam int TS_W  = 32;
    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } qpd_state_e;

    // True when the sample now being counted is the final one of the burst.
    function automatic logic is_last_sample(input logic [LEN_W-1:0] cnt,
                                            input logic [LEN_W-1:0] len);
        return ({1'b0, cnt} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len};
    endfunction

endpackage

// File: rtl/qpd_burst_capture_if.sv
// Readout stream between the capture FIFO and the host path.
// Handshake: the master holds out_data stable while out_valid is high;
// a sample moves on every sclock edge where out_valid && out_ready,
// and the slave may drive out_ready independently of out_valid.
interface qpd_burst_capture_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/qpd_capture_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head sample is read
// straight from the storage registers so a write lands on rd_data
// one cycle later. Writes to a full FIFO are ignored.
module qpd_capture_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              sclock,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; full is judged before any same-cycle read.
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en && !full) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/qpd_burst_capture.sv
// Captures a burst of ADC samples after a trigger pulse and streams them
// out. Optional trigger timestamp enabled by QPD_CAPTURE_TIMESTAMP_EN.
module qpd_burst_capture
    import qpd_capture_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                sclock,
    input  logic                rst_n,
    input  logic                trigger,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic                adc_valid,
    qpd_burst_capture_if.master out_if,
    output logic                busy,
    output logic                overflow,
    output logic                done,
    output logic [TS_W-1:0]     trig_time,
    output qpd_state_e          state_dbg
);
    localparam int AW = $clog2(DEPTH);

    qpd_state_e       state_q, state_d;
    logic [LEN_W-1:0] len_q, cnt_q;
    logic             overflow_q, done_q;
    logic             accept_trig, fifo_wr, drop, cnt_inc, done_set;
    logic             fifo_full, fifo_empty, rd_en, drain_exit;
    logic [AW:0]      fifo_count;

    qpd_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .sclock  (sclock),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (adc_data),
        .rd_en   (rd_en),
        .rd_data (out_if.out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_if.out_valid = !fifo_empty;
    assign rd_en            = out_if.out_valid && out_if.out_ready;
    // DRAIN finishes on the edge that moves the last sample out.
    assign drain_exit       = fifo_empty || (rd_en && fifo_count == (AW+1)'(1));
    assign overflow         = overflow_q;
    assign done             = done_q;
    assign state_dbg        = state_q;

    // State register.
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (trigger && burst_len != '0)                 state_d = ST_CAPTURE;
            ST_CAPTURE: if (adc_valid && is_last_sample(cnt_q, len_q))  state_d = ST_DRAIN;
            ST_DRAIN:   if (drain_exit)                                 state_d = ST_IDLE;
            default:                                                    state_d = ST_IDLE;
        endcase
    end

    // State-decoded controls; triggers outside IDLE are simply not accepted.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        accept_trig = (state_q == ST_IDLE) && trigger;
        cnt_inc     = (state_q == ST_CAPTURE) && adc_valid;
        fifo_wr     = cnt_inc && !fifo_full;
        drop        = cnt_inc && fifo_full;
        done_set    = (accept_trig && burst_len == '0) ||
                      ((state_q == ST_DRAIN) && drain_exit);
    end

    // Burst length, sample counter, sticky overflow and done pulse.
    // Dropped samples still count so the burst length stays time-aligned.
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= done_set;
            if (accept_trig) begin
                len_q      <= burst_len;
                cnt_q      <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (cnt_inc) cnt_q      <= cnt_q + 1'b1;
                if (drop)    overflow_q <= 1'b1;
            end
        end
    end

`ifdef QPD_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, trig_time_q;

    // Free-running timestamp; its value is latched on each accepted trigger.
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            ts_q        <= '0;
            trig_time_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if (accept_trig) trig_time_q <= ts_q;
        end
    end

    assign trig_time = trig_time_q;
`else
    assign trig_time = '0;
`endif

endmodule

// File: tb/tb_qpd_burst_capture.sv
// Self-checking bench for qpd_burst_capture (DATA_W=16, DEPTH=16).
module tb_qpd_burst_capture;
    import qpd_capture_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;

    logic              sclock = 1'b0;
    logic              rst_n  = 1'b0;
    logic              trigger = 1'b0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              adc_valid = 1'b0;
    logic              busy, overflow, done;
    logic [TS_W-1:0]   trig_time;
    qpd_state_e        state_dbg;

    qpd_burst_capture_if #(.DATA_W(DATA_W)) out_if ();

    qpd_burst_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .sclock    (sclock),
        .rst_n     (rst_n),
        .trigger   (trigger),
        .burst_len (burst_len),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .out_if    (out_if),
        .busy      (busy),
        .overflow  (overflow),
        .done      (done),
        .trig_time (trig_time),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 sclock = ~sclock;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int out_cnt  = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: compare each transfer against the expected queue
    always @(negedge sclock) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (out_if.out_valid && out_if.out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) check("unexpected_out", 32'(out_if.out_data), 32'hdead_beef);
                else                   check("out_data", 32'(out_if.out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge sclock);
        #1;
    endtask

    task automatic fire_trigger(input logic [LEN_W-1:0] len);
        burst_len = len;
        trigger   = 1'b1;
        step();
        trigger   = 1'b0;
    endtask

    task automatic drive_sample(input logic [DATA_W-1:0] d, input logic v);
        adc_data  = d;
        adc_valid = v;
        step();
    endtask

    task automatic wait_done(input int start, input int max_cyc, input bit rand_ready);
        for (int i = 0; i < max_cyc && done_cnt == start; i++) begin
            if (rand_ready) out_if.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        check("done_seen", 32'(done_cnt != start), 32'd1);
    endtask

    int d0, o0;

    initial begin
        out_if.out_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // reset state
        @(negedge sclock);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_if.out_valid), 0);
        check("rst_data", 32'(out_if.out_data), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_done", 32'(done), 0);
        check("rst_trig_time", trig_time, 0);
        step();

        // basic burst of 4
        out_if.out_ready = 1'b1;
        d0 = done_cnt; o0 = out_cnt;
        for (int i = 1; i <= 4; i++) exp_q.push_back(DATA_W'(i));
        fire_trigger(8'd4);
        for (int i = 1; i <= 4; i++) drive_sample(DATA_W'(i), 1'b1);
        adc_valid = 1'b0;
        wait_done(d0, 50, 1'b0);
        repeat (3) step();
        @(negedge sclock);
        check("t1_done_once", 32'(done_cnt - d0), 1);
        check("t1_out_count", 32'(out_cnt - o0), 4);
        check("t1_busy", 32'(busy), 0);
        check("t1_overflow", 32'(overflow), 0);
        step();

        // zero-length trigger
        d0 = done_cnt;
        fire_trigger(8'd0);
        @(negedge sclock);
        check("t2_done_pulse", 32'(done), 1);
        check("t2_busy", 32'(busy), 0);
        check("t2_valid", 32'(out_if.out_valid), 0);
        step();
        @(negedge sclock);
        check("t2_done_low", 32'(done), 0);
        check("t2_busy_after", 32'(busy), 0);
        step();

        // overflow: 20 samples into 16 entries with the reader stalled
        out_if.out_ready = 1'b0;
        d0 = done_cnt; o0 = out_cnt;
        for (int i = 0; i < 16; i++) exp_q.push_back(DATA_W'(16'h0100 + i));
        fire_trigger(8'd20);
        for (int i = 0; i < 20; i++) drive_sample(DATA_W'(16'h0100 + i), 1'b1);
        adc_valid = 1'b0;
        repeat (4) step();
        @(negedge sclock);
        check("t3_overflow", 32'(overflow), 1);
        check("t3_busy_stalled", 32'(busy), 1);
        check("t3_no_done_yet", 32'(done_cnt - d0), 0);
        step();
        out_if.out_ready = 1'b1;
        wait_done(d0, 100, 1'b0);
        repeat (2) step();
        @(negedge sclock);
        check("t3_out_count", 32'(out_cnt - o0), 16);
        check("t3_done_once", 32'(done_cnt - d0), 1);
        check("t3_overflow_sticky", 32'(overflow), 1);
        step();

        // retrigger during capture is ignored
        d0 = done_cnt; o0 = out_cnt;
        for (int i = 0; i < 8; i++) exp_q.push_back(DATA_W'(16'h0200 + i));
        fire_trigger(8'd8);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                trigger   = 1'b1;
                burst_len = 8'd3;
            end
            drive_sample(DATA_W'(16'h0200 + i), 1'b1);
            trigger = 1'b0;
        end
        adc_valid = 1'b0;
        wait_done(d0, 50, 1'b0);
        repeat (4) step();
        @(negedge sclock);
        check("t4_out_count", 32'(out_cnt - o0), 8);
        check("t4_done_once", 32'(done_cnt - d0), 1);
        check("t4_overflow_cleared", 32'(overflow), 0);
        step();

        // gapped input with random backpressure
        d0 = done_cnt; o0 = out_cnt;
        fire_trigger(8'd10);
        for (int c = 0; c < 30; c++) begin
            logic [DATA_W-1:0] d;
            d = DATA_W'($urandom_range(0, 16'hffff));
            out_if.out_ready = 1'($urandom_range(0, 1));
            if (c % 3 == 0) exp_q.push_back(d);
            drive_sample(d, c % 3 == 0);
        end
        adc_valid = 1'b0;
        wait_done(d0, 200, 1'b1);
        out_if.out_ready = 1'b1;
        repeat (3) step();
        @(negedge sclock);
        check("t5_out_count", 32'(out_cnt - o0), 10);
        check("t5_overflow", 32'(overflow), 0);
        check("t5_done_once", 32'(done_cnt - d0), 1);
        step();

        // reset in the middle of a burst
        out_if.out_ready = 1'b0;
        fire_trigger(8'd8);
        for (int i = 0; i < 3; i++) drive_sample(DATA_W'(16'h0300 + i), 1'b1);
        adc_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("t6_busy", 32'(busy), 0);
        check("t6_valid", 32'(out_if.out_valid), 0);
        check("t6_data", 32'(out_if.out_data), 0);
        check("t6_done", 32'(done), 0);
        step();
        step();
        rst_n = 1'b1;
        out_if.out_ready = 1'b1;
        step();
        @(negedge sclock);
        check("t6_valid_after", 32'(out_if.out_valid), 0);
        step();

`ifdef QPD_CAPTURE_TIMESTAMP_EN
        // reset released, then 2 edges consumed above; trigger accepted at edge 101
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (100) step();
        fire_trigger(8'd0);
        @(negedge sclock);
        check("t6_trig_time", trig_time, 32'd100);
        step();
`else
        fire_trigger(8'd0);
        @(negedge sclock);
        check("t6_trig_time_off", trig_time, 32'd0);
        step();
`endif

        repeat (3) step();
        check("exp_q_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
